// File: rtl/pipe_collision_pkg.sv
// rtl/pipe_collision_pkg.sv - shared game constants, state encoding and score helpers
package pipe_collision_pkg;

    localparam int SCREEN_HEIGHT = 480;
    localparam int BIRD_HEIGHT   = 20;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DEAD  = 2'b10
    } game_state_e;

    // Two packed BCD digits, tens in [7:4], holding at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bin_inc_sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gap_lfsr.sv
// rtl/gap_lfsr.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4) choosing the next pipe gap
module gap_lfsr
    import pipe_collision_pkg::*;
(
    input  logic       gameClk,
    input  logic       reset,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       feedback;

    assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d   = {lfsr_q[6:0], feedback};

    always_ff @(posedge gameClk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/pipe_collision.sv
// rtl/pipe_collision.sv - pipe scroller, collision detect, scoring and game FSM
// Optional SCORE_BCD_EN: score counts as two BCD digits instead of binary.
module pipe_collision
    import pipe_collision_pkg::*;
#(
    parameter int SCREEN_WIDTH = 640,
    parameter int PIPE_WIDTH   = 40,
    parameter int PIPE_SPEED   = 2,
    parameter int GAP_HEIGHT   = 120,
    parameter int GAP_MIN      = 60,
    parameter int BIRD_X       = 100
) (
    input  logic               gameClk,
    input  logic               reset,
    input  logic               button,
    input  logic signed [10:0] bird_y,
    output logic               finished,
    output logic        [10:0] pipe_x,
    output logic        [10:0] gap_y,
    output logic        [7:0]  score,
    output logic        [1:0]  state
);

    localparam logic [10:0]        SW_U       = 11'(SCREEN_WIDTH);
    localparam logic [10:0]        SPEED_U    = 11'(PIPE_SPEED);
    localparam logic [10:0]        GAP_MIN_U  = 11'(GAP_MIN);
    localparam logic [11:0]        PIPE_W_U   = 12'(PIPE_WIDTH);
    localparam logic [11:0]        BIRD_L_U   = 12'(BIRD_X);
    localparam logic [11:0]        BIRD_R_U   = 12'(BIRD_X + BIRD_HEIGHT);
    localparam logic signed [11:0] BIRD_H_S   = 12'(BIRD_HEIGHT);
    localparam logic signed [11:0] GAP_H_S    = 12'(GAP_HEIGHT);

    game_state_e state_q, state_d;
    logic [10:0] pipe_x_q, pipe_x_d;
    logic [10:0] gap_y_q, gap_y_d;
    logic [7:0]  score_q, score_d;
    logic        passed_q, passed_d;
    logic [7:0]  lfsr_value;

    logic [11:0]        px_u;
    logic [11:0]        pipe_right_u;
    logic signed [11:0] by_s;
    logic signed [11:0] gy_s;
    logic signed [11:0] bird_top_s;
    logic signed [11:0] gap_top_s;
    logic               overlap;
    logic               vmiss;
    logic               on_floor;
    logic               collision;
    logic               wrap;
    logic               pipe_cleared;
    logic [7:0]         score_inc;

    gap_lfsr u_gap_lfsr (
        .gameClk (gameClk),
        .reset   (reset),
        .value   (lfsr_value)
    );

    assign px_u         = {1'b0, pipe_x_q};
    assign pipe_right_u = px_u + PIPE_W_U;
    assign by_s         = {bird_y[10], bird_y};
    assign gy_s         = {1'b0, gap_y_q};
    assign bird_top_s   = by_s + BIRD_H_S;
    assign gap_top_s    = gy_s + GAP_H_S;

    assign overlap      = (px_u < BIRD_R_U) && (pipe_right_u > BIRD_L_U);
    assign vmiss        = (by_s < gy_s) || (bird_top_s > gap_top_s);
    assign on_floor     = (by_s <= BIRD_H_S);
    assign collision    = (overlap && vmiss) || on_floor;
    assign wrap         = (pipe_x_q < SPEED_U);
    assign pipe_cleared = (pipe_right_u < BIRD_L_U) && !passed_q;

    always_comb begin
        score_inc = score_q;
`ifdef SCORE_BCD_EN
        score_inc = bcd_inc_sat(score_q);
`else
        score_inc = bin_inc_sat(score_q);
`endif
    end

    always_comb begin
        state_d  = state_q;
        pipe_x_d = pipe_x_q;
        gap_y_d  = gap_y_q;
        score_d  = score_q;
        passed_d = passed_q;
        case (state_q)
            ST_READY: begin
                if (button) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A collision freezes the pipe where it is, including on a wrap edge.
                if (collision) begin
                    state_d = ST_DEAD;
                end else if (wrap) begin
                    pipe_x_d = SW_U;
                    gap_y_d  = GAP_MIN_U + {3'b000, lfsr_value};
                    passed_d = 1'b0;
                end else begin
                    pipe_x_d = pipe_x_q - SPEED_U;
                end
                if (pipe_cleared) begin
                    passed_d = 1'b1;
                    score_d  = score_inc;
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge gameClk) begin
        if (reset) begin
            state_q  <= ST_READY;
            pipe_x_q <= SW_U;
            gap_y_q  <= GAP_MIN_U + {3'b000, LFSR_SEED};
            score_q  <= 8'd0;
            passed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pipe_x_q <= pipe_x_d;
            gap_y_q  <= gap_y_d;
            score_q  <= score_d;
            passed_q <= passed_d;
        end
    end

    assign state    = state_q;
    assign finished = (state_q == ST_DEAD);
    assign pipe_x   = pipe_x_q;
    assign gap_y    = gap_y_q;
    assign score    = score_q;

endmodule
